// File: rtl/writeback_unit_if.sv
// Writeback stage bus: MEM-stage retiring instruction, load return, stall back to the
// pipeline and the register-file write port. Optional forwarding outputs appear when
// WB_BYPASS_EN is defined.
interface writeback_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_regWrite;
  logic             in_memToReg;
  logic [4:0]       in_rd;
  logic [31:0]      in_aluResult;
  logic [31:0]      load_data;
  logic             load_ready;
  logic             flush;
  logic             stall_req;
  logic             writeSignal;
  logic [4:0]       RegisterAddress;
  logic [31:0]      WriteData;
  logic [CNT_W-1:0] retire_count;
`ifdef WB_BYPASS_EN
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [31:0]      fwd_data;

  modport master (
    output in_valid, in_regWrite, in_memToReg, in_rd, in_aluResult,
    output load_data, load_ready, flush,
    input  stall_req, writeSignal, RegisterAddress, WriteData, retire_count,
    input  fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_regWrite, in_memToReg, in_rd, in_aluResult,
    input  load_data, load_ready, flush,
    output stall_req, writeSignal, RegisterAddress, WriteData, retire_count,
    output fwd_valid, fwd_rd, fwd_data
  );
`else
  modport master (
    output in_valid, in_regWrite, in_memToReg, in_rd, in_aluResult,
    output load_data, load_ready, flush,
    input  stall_req, writeSignal, RegisterAddress, WriteData, retire_count
  );

  modport slave (
    input  in_valid, in_regWrite, in_memToReg, in_rd, in_aluResult,
    input  load_data, load_ready, flush,
    output stall_req, writeSignal, RegisterAddress, WriteData, retire_count
  );
`endif
endinterface

// File: rtl/writeback_unit.sv
// MIPS WB stage: latches the retiring instruction, waits for outstanding load data,
// and issues exactly one register-file write per retired instruction.
// Optional feature macro: WB_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data for EX forwarding.
module writeback_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  writeback_unit_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_we_q, pend_we_d;
  logic             we_q, we_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state and registered write-port values.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_we_d = pend_we_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.in_memToReg && !bus.load_ready) begin
            state_d   = StWait;
            pend_rd_d = bus.in_rd;
            pend_we_d = bus.in_regWrite;
          end else begin
            we_d   = bus.in_regWrite && (bus.in_rd != 5'd0);
            addr_d = bus.in_rd;
            data_d = bus.in_memToReg ? bus.load_data : bus.in_aluResult;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        // Flush wins over a same-cycle load return; in_valid is ignored while stalled.
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.load_ready) begin
          state_d = StIdle;
          we_d    = pend_we_q && (pend_rd_q != 5'd0);
          addr_d  = pend_rd_q;
          data_d  = bus.load_data;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pend_rd_q <= 5'd0;
      pend_we_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 5'd0;
      data_q    <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_we_q <= pend_we_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stall is combinational so it drops in the same cycle load_ready rises.
  assign bus.stall_req = !bus.flush && !bus.load_ready &&
                         ((state_q == StWait) ||
                          ((state_q == StIdle) && bus.in_valid && bus.in_memToReg));

  assign bus.writeSignal     = we_q;
  assign bus.RegisterAddress = addr_q;
  assign bus.WriteData       = data_q;
  assign bus.retire_count    = cnt_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = we_q && (addr_q != 5'd0);
  assign bus.fwd_rd    = addr_q;
  assign bus.fwd_data  = data_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, hand sequences for
// counter wrap, and randomized traffic against a transaction-level reference model.
module tb_writeback_unit;
  localparam int unsigned CntW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_unit_if #(.CNT_W(CntW)) wb ();

  writeback_unit #(.CNT_W(CntW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (wb)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit rst, v, rw, m2r, input logic [4:0] rd,
                        input logic [31:0] alu, ld, input bit rdy, fl);
    reset           = rst;
    wb.in_valid     = v;
    wb.in_regWrite  = rw;
    wb.in_memToReg  = m2r;
    wb.in_rd        = rd;
    wb.in_aluResult = alu;
    wb.load_data    = ld;
    wb.load_ready   = rdy;
    wb.flush        = fl;
  endtask

  task automatic chk_outs(input string tag, input bit e_we, input logic [4:0] e_addr,
                          input logic [31:0] e_data, input int e_cnt);
    chk({tag, "_we"}, 32'(wb.writeSignal), 32'(e_we));
    chk({tag, "_addr"}, 32'(wb.RegisterAddress), 32'(e_addr));
    chk({tag, "_data"}, wb.WriteData, e_data);
    chk({tag, "_cnt"}, 32'(wb.retire_count), 32'(e_cnt));
`ifdef WB_BYPASS_EN
    chk({tag, "_fwdv"}, 32'(wb.fwd_valid), 32'(e_we && (e_addr != 5'd0)));
    chk({tag, "_fwdrd"}, 32'(wb.fwd_rd), 32'(e_addr));
    chk({tag, "_fwdd"}, wb.fwd_data, e_data);
`endif
  endtask

  // Directed vectors: inputs applied for one cycle, stall checked before the edge,
  // registered outputs checked after it.
  typedef struct {
    bit          rst, v, rw, m2r;
    logic [4:0]  rd;
    logic [31:0] alu, ld;
    bit          rdy, fl;
    bit          e_stall, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, v, rw, m2r, input logic [4:0] rd,
                     input logic [31:0] alu, ld, input bit rdy, fl, e_stall, e_we,
                     input logic [4:0] e_addr, input logic [31:0] e_data, input int e_cnt);
    vec_t t;
    t = '{rst, v, rw, m2r, rd, alu, ld, rdy, fl, e_stall, e_we, e_addr, e_data, e_cnt};
    vecs.push_back(t);
  endtask

  // Reference model: at most one pending load, counter modulo 2^CntW.
  bit          m_pend;
  logic [4:0]  m_prd;
  bit          m_pwe;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic model_reset();
    m_pend = 0; m_prd = 0; m_pwe = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic retire(input bit rw, input logic [4:0] rd, input logic [31:0] d);
    m_we   = rw && (rd != 0);
    m_addr = rd;
    m_data = d;
    m_cnt  = (m_cnt + 1) % (1 << CntW);
  endtask

  task automatic rand_step(input string tag, input bit rst, v, rw, m2r,
                           input logic [4:0] rd, input logic [31:0] alu, ld,
                           input bit rdy, fl);
    bit e_stall;
    set_in(rst, v, rw, m2r, rd, alu, ld, rdy, fl);
    #1;
    e_stall = !fl && !rdy && (m_pend || (v && m2r));
    chk({tag, "_stall"}, 32'(wb.stall_req), 32'(e_stall));
    m_we = 0;
    if (rst) begin
      model_reset();
    end else if (m_pend) begin
      if (fl) m_pend = 0;
      else if (rdy) begin
        m_pend = 0;
        retire(m_pwe, m_prd, ld);
      end
    end else if (v && !fl) begin
      if (m2r && !rdy) begin
        m_pend = 1; m_prd = rd; m_pwe = rw;
      end else begin
        retire(rw, rd, m2r ? ld : alu);
      end
    end
    @(posedge clock);
    #1;
    chk_outs(tag, m_we, m_addr, m_data, m_cnt);
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;

    //  rst v rw m2r rd  alu          ld           rdy fl | stall we addr data cnt
    add(1, 0, 0, 0, 0,  0,           0,           0, 0,   0, 0, 0,  0,            0);
    add(0, 1, 1, 0, 5,  32'h2A,      0,           0, 0,   0, 1, 5,  32'h2A,       1);
    add(0, 0, 0, 0, 0,  0,           0,           0, 0,   0, 0, 5,  32'h2A,       1);
    add(0, 1, 1, 1, 10, 0,           0,           0, 0,   1, 0, 5,  32'h2A,       1);
    add(0, 1, 1, 1, 10, 0,           0,           0, 0,   1, 0, 5,  32'h2A,       1);
    add(0, 1, 1, 1, 10, 0,           0,           0, 0,   1, 0, 5,  32'h2A,       1);
    add(0, 1, 1, 1, 10, 0,           32'hDEADBEEF, 1, 0,  0, 1, 10, 32'hDEADBEEF, 2);
    add(0, 0, 0, 0, 0,  0,           0,           0, 0,   0, 0, 10, 32'hDEADBEEF, 2);
    add(0, 1, 1, 0, 0,  7,           0,           0, 0,   0, 0, 0,  7,            3);
    add(0, 1, 1, 1, 4,  0,           0,           0, 0,   1, 0, 0,  7,            3);
    add(0, 1, 1, 1, 4,  0,           32'h44,      1, 1,   0, 0, 0,  7,            3);
    add(0, 0, 0, 0, 0,  0,           0,           0, 0,   0, 0, 0,  7,            3);
    add(0, 1, 1, 1, 9,  0,           0,           0, 0,   1, 0, 0,  7,            3);
    add(1, 0, 0, 0, 0,  0,           0,           0, 0,   1, 0, 0,  0,            0);
    add(0, 0, 0, 0, 0,  0,           0,           0, 0,   0, 0, 0,  0,            0);
    add(0, 1, 1, 0, 3,  32'h33,      0,           0, 0,   0, 1, 3,  32'h33,       1);
    add(0, 1, 1, 0, 4,  32'h44,      0,           0, 0,   0, 1, 4,  32'h44,       2);
    add(0, 1, 0, 1, 6,  0,           32'h66,      1, 0,   0, 0, 6,  32'h66,       3);
    add(0, 1, 1, 0, 7,  32'h77,      0,           0, 1,   0, 0, 6,  32'h66,       3);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_in(vecs[i].rst, vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].rd,
             vecs[i].alu, vecs[i].ld, vecs[i].rdy, vecs[i].fl);
      #1;
      chk({tag, "_stall"}, 32'(wb.stall_req), 32'(vecs[i].e_stall));
      @(posedge clock);
      #1;
      chk_outs(tag, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cnt);
    end

    // Counter wrap: 17 retirements from reset leave retire_count at 1.
    model_reset();
    rand_step("wrap_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      rand_step($sformatf("wrap%0d", i), 0, 1, 1, 0, 5'(i % 31 + 1), 32'(i * 3), 0, 0, 0);
    end
    chk("wrap_final", 32'(wb.retire_count), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit rst, v, rw, m2r, rdy, fl;
      rst = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rw  = ($urandom_range(0, 3) != 0);
      m2r = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 4) < 2);
      fl  = ($urandom_range(0, 9) == 0);
      rand_step($sformatf("rnd%0d", i), rst, v, rw, m2r, 5'($urandom_range(0, 31)),
                $urandom, $urandom, rdy, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
